// File: rtl/serial_slice_adder.sv
// Multi-cycle adder/subtractor: one SLICE-wide adder reused over the word
// through a registered carry, with start/busy/done handshake and flags.
`timescale 1ns/1ps
module serial_slice_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   slice_res;
  logic             accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign accept = (state_q != RUN) && start;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    a_sl      = a_q[cnt_q*SLICE +: SLICE];
    b_sl      = b_q[cnt_q*SLICE +: SLICE];
    slice_res = {1'b0, a_sl} + {1'b0, b_sl}
              + {{SLICE{1'b0}}, carry_q};
    if (accept) begin
      a_d     = a;
      b_d     = subtract ? ~b : b;
      carry_d = subtract;
      cnt_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
      zero_d  = 1'b0;
    end else if (state_q == RUN) begin
      sum_d[cnt_q*SLICE +: SLICE] = slice_res[SLICE-1:0];
      carry_d = slice_res[SLICE];
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        // carry into MSB recovered as a^b^s at the top bit
        cout_d = slice_res[SLICE];
        ovf_d  = a_sl[SLICE-1] ^ b_sl[SLICE-1]
               ^ slice_res[SLICE-1] ^ slice_res[SLICE];
        zero_d = (sum_d == '0);
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign carryout = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_slice_adder.sv
// Scoreboard bench: three adder instances (SLICE 2, 1, 8) at WIDTH 8
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_slice_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   start_v = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         subtract = 1'b0;
  int           cyc = 0;
  int           passed = 0;
  int           total = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
    int           t;
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                 logic sub, int t);
    exp_t e;
    int   ux = int'(x);
    int   uy = int'(y);
    int   sx = $signed(x);
    int   sy = $signed(y);
    int   full;
    int   sres;
    full = sub ? ux - uy : ux + uy;
    sres = sub ? sx - sy : sx + sy;
    e.s  = full[W-1:0];
    e.c  = sub ? (ux >= uy) : (full >= 256);
    e.v  = (sres > 127) || (sres < -128);
    e.z  = (e.s == '0);
    e.t  = t;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int SL = (g == 0) ? 2 : (g == 1) ? 1 : 8;
    localparam int N  = W / SL;
    logic         busy, done, co, ov, zr;
    logic [W-1:0] sum;
    exp_t         q[$];
    exp_t         e;
    int           bcnt = 0;

    serial_slice_adder #(.WIDTH(W), .SLICE(SL)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start_v[g]),
      .a        (a),
      .b        (b),
      .subtract (subtract),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .carryout (co),
      .overflow (ov),
      .zero     (zr)
    );

    always @(negedge clk) begin
      if (done) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL u%0d done: got unexpected pulse, expected none", g);
        end else begin
          e = q.pop_front();
          check($sformatf("u%0d sum", g), 32'(sum), 32'(e.s));
          check($sformatf("u%0d carryout", g), 32'(co), 32'(e.c));
          check($sformatf("u%0d overflow", g), 32'(ov), 32'(e.v));
          check($sformatf("u%0d zero", g), 32'(zr), 32'(e.z));
          check($sformatf("u%0d latency", g), cyc - e.t, N);
          check($sformatf("u%0d busy cycles", g), bcnt, N);
        end
        bcnt = 0;
      end
      if (busy) bcnt++;
      if (reset) begin
        q.delete();
        bcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [2:0] m, logic [W-1:0] x,
                       logic [W-1:0] y, logic sub);
    exp_t e;
    a        = x;
    b        = y;
    subtract = sub;
    start_v  = m;
    e = model(x, y, sub, cyc + 1);
    if (m[0]) u[0].q.push_back(e);
    if (m[1]) u[1].q.push_back(e);
    if (m[2]) u[2].q.push_back(e);
    tick();
    start_v = '0;
  endtask

  function automatic int pending();
    return u[0].q.size() + u[1].q.size() + u[2].q.size();
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (pending() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (pending() != 0) begin
      total++;
      $display("FAIL wait_done: got %0d pending after timeout, expected 0",
               pending());
      u[0].q.delete();
      u[1].q.delete();
      u[2].q.delete();
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h7F;
      2:       return 8'h80;
      3:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  logic [W-1:0] da [6] = '{8'h0F, 8'h7F, 8'hFF, 8'h05, 8'h80, 8'h00};
  logic [W-1:0] db [6] = '{8'h01, 8'h01, 8'h01, 8'h05, 8'h01, 8'h01};
  logic         ds [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    tick();
    tick();
    check("u0 reset outs", {u[0].busy, u[0].done, u[0].sum,
          u[0].co, u[0].ov, u[0].zr}, 0);
    check("u1 reset outs", {u[1].busy, u[1].done, u[1].sum,
          u[1].co, u[1].ov, u[1].zr}, 0);
    check("u2 reset outs", {u[2].busy, u[2].done, u[2].sum,
          u[2].co, u[2].ov, u[2].zr}, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      issue(3'b111, da[i], db[i], ds[i]);
      wait_idle();
    end

    issue(3'b001, 8'h0F, 8'h01, 1'b0);
    tick();
    a       = 8'hAA;
    b       = 8'h55;
    start_v = 3'b001;
    tick();
    start_v = '0;
    wait_idle();

    issue(3'b001, 8'h33, 8'h44, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("u0 abort outs", {u[0].busy, u[0].done, u[0].sum,
          u[0].co, u[0].ov, u[0].zr}, 0);
    repeat (8) tick();
    issue(3'b001, 8'h12, 8'h34, 1'b1);
    wait_idle();

    for (int j = 0; j < 5; j++) begin
      a        = pick();
      b        = pick();
      subtract = 1'($urandom);
      u[0].q.push_back(model(a, b, subtract, cyc + 1));
      start_v  = 3'b001;
      tick();
      if (j == 4) start_v = '0;
      repeat (4) tick();
    end
    wait_idle();

    for (int i = 0; i < 2500; i++) begin
      issue(3'b111, pick(), pick(), 1'($urandom));
      wait_idle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
